// File: rtl/shift_seq_pkg.sv
// Shared types, the 7-segment code table and helpers for the walking-bit sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {RING_L, RING_R, JOHNSON, PINGPONG} seq_mode_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  // {dp,g,f,e,d,c,b,a}, dp held low; index 0 is digit 0.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Control and display bundle between the board-level driver and the sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
);
  // No handshake: controls are sampled on every clk_2 edge and outputs are
  // level signals valid from the edge that produced them; dbg_dir exposes state.
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] pattern;
  logic [IDXW-1:0]  index;
  logic             wrap;
  logic [7:0]       seg;
  logic             dbg_dir;

  modport master (
    output en, mode, load, load_val,
    input  pattern, index, wrap, seg, dbg_dir
  );

  modport slave (
    input  en, mode, load, load_val,
    output pattern, index, wrap, seg, dbg_dir
  );
endinterface

// File: rtl/shift_sequencer_hex7seg.sv
// Combinational hex digit to 7-segment decoder.
module hex7seg
  import shift_seq_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [7:0] o_seg
);
  assign o_seg = SEG_HEX[i_hex];
endmodule

// File: rtl/shift_sequencer.sv
// Walking-bit pattern generator: prescaled steps in ring, Johnson or ping-pong mode.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1,
  parameter int IDXW     = $clog2(WIDTH)
) (
  input logic               clk_2,
  input logic               reset,
  shift_sequencer_if.slave  bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [WIDTH-1:0] r_pattern;
  logic [IDXW-1:0]  r_index;
  logic             r_wrap;
  dir_t             r_dir;
  logic [CW-1:0]    r_cnt;

  logic             w_step;
  logic [WIDTH-1:0] w_next;
  dir_t             w_next_dir;
  logic             w_next_wrap;
  logic             w_onehot;
  seq_mode_t        w_mode;
  logic [3:0]       w_hex;

  function automatic logic [IDXW-1:0] lsb_index(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  assign w_mode   = seq_mode_t'(bus.mode);
  assign w_onehot = is_onehot(16'(r_pattern));
  assign w_step   = bus.en && (r_cnt == CW'(PRESCALE - 1));

  always_comb begin
    w_next      = r_pattern;
    w_next_dir  = DIR_UP;
    w_next_wrap = 1'b0;
    case (w_mode)
      RING_L: begin
        if (!w_onehot) begin
          w_next = WIDTH'(1);
        end else begin
          w_next      = {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]};
          w_next_wrap = r_pattern[WIDTH-1];
        end
      end
      RING_R: begin
        if (!w_onehot) begin
          w_next = WIDTH'(1);
        end else begin
          w_next      = {r_pattern[0], r_pattern[WIDTH-1:1]};
          w_next_wrap = r_pattern[0];
        end
      end
      JOHNSON: begin
        w_next      = {r_pattern[WIDTH-2:0], ~r_pattern[WIDTH-1]};
        w_next_wrap = ({r_pattern[WIDTH-2:0], ~r_pattern[WIDTH-1]} == '0);
      end
      PINGPONG: begin
        if (!w_onehot) begin
          w_next = WIDTH'(1);
        end else if (r_dir == DIR_UP && !r_pattern[WIDTH-1]) begin
          w_next     = r_pattern << 1;
          w_next_dir = r_pattern[WIDTH-2] ? DIR_DOWN : DIR_UP;
        end else begin
          // Also covers an upward walker already parked on the MSB: bounce back.
          w_next = r_pattern >> 1;
          if (r_pattern[1]) begin
            w_next_dir  = DIR_UP;
            w_next_wrap = 1'b1;
          end else begin
            w_next_dir = DIR_DOWN;
          end
        end
      end
      default: w_next = r_pattern;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_pattern <= WIDTH'(1);
      r_index   <= '0;
      r_wrap    <= 1'b0;
      r_dir     <= DIR_UP;
      r_cnt     <= '0;
    end else if (bus.load) begin
      r_pattern <= bus.load_val;
      r_index   <= lsb_index(bus.load_val);
      r_wrap    <= 1'b0;
      r_dir     <= DIR_UP;
      r_cnt     <= '0;
    end else begin
      r_wrap <= 1'b0;
      if (w_step) begin
        r_cnt     <= '0;
        r_pattern <= w_next;
        r_index   <= lsb_index(w_next);
        r_wrap    <= w_next_wrap;
        r_dir     <= w_next_dir;
      end else if (bus.en) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_mode != PINGPONG) r_dir <= DIR_UP;
    end
  end

  assign w_hex = 4'(r_index);

  hex7seg u_hex7seg (
    .i_hex (w_hex),
    .o_seg (bus.seg)
  );

  assign bus.pattern = r_pattern;
  assign bus.index   = r_index;
  assign bus.wrap    = r_wrap;
  assign bus.dbg_dir = (r_dir == DIR_DOWN);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: two instances (PRESCALE 1 and 3) against a position-level model.
module tb_shift_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         ld;
  logic [W-1:0] ld_val;
  bit           chk_en;

  int n_cmp = 0;
  int n_bad = 0;

  int m_pat  [2];
  int m_dir  [2];
  int m_wrap [2];
  int m_cnt  [2];

  int exp_seg [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  shift_sequencer_if #(.WIDTH(W)) bus0 ();
  shift_sequencer_if #(.WIDTH(W)) bus1 ();

  assign bus0.en = en;  assign bus0.mode = mode;  assign bus0.load = ld;  assign bus0.load_val = ld_val;
  assign bus1.en = en;  assign bus1.mode = mode;  assign bus1.load = ld;  assign bus1.load_val = ld_val;

  shift_sequencer #(.WIDTH(W), .PRESCALE(1)) dut0 (.clk_2(clk), .reset(rst), .bus(bus0));
  shift_sequencer #(.WIDTH(W), .PRESCALE(3)) dut1 (.clk_2(clk), .reset(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int low_bit(input int p);
    for (int i = 0; i < W; i++) if (p[i]) return i;
    return 0;
  endfunction

  // Step the model one pattern step using bit positions and arithmetic.
  task automatic model_step(input int k);
    int p, mask, pos;
    p = m_pat[k];
    mask = (1 << W) - 1;
    m_wrap[k] = 0;
    case (mode)
      2'd0: if ($countones(p) != 1) p = 1;
            else begin m_wrap[k] = (p >> (W - 1)) & 1; p = ((p << 1) | (p >> (W - 1))) & mask; end
      2'd1: if ($countones(p) != 1) p = 1;
            else begin m_wrap[k] = p & 1; p = ((p >> 1) | ((p & 1) << (W - 1))) & mask; end
      2'd2: begin p = ((p << 1) | (~(p >> (W - 1)) & 1)) & mask; m_wrap[k] = (p == 0); end
      default: begin
        if ($countones(p) != 1) begin
          p = 1; m_dir[k] = 0;
        end else begin
          pos = $clog2(p);
          if (m_dir[k] == 0 && pos < W - 1) begin
            pos++;
            if (pos == W - 1) m_dir[k] = 1;
          end else begin
            pos--;
            if (pos == 0) begin m_dir[k] = 0; m_wrap[k] = 1; end
            else m_dir[k] = 1;
          end
          p = 1 << pos;
        end
      end
    endcase
    m_pat[k] = p;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pat[k] = 1; m_dir[k] = 0; m_wrap[k] = 0; m_cnt[k] = 0;
      end else if (ld) begin
        m_pat[k] = int'(ld_val); m_dir[k] = 0; m_wrap[k] = 0; m_cnt[k] = 0;
      end else begin
        m_wrap[k] = 0;
        if (en) begin
          if (m_cnt[k] == ((k == 0) ? 0 : 2)) begin
            m_cnt[k] = 0;
            model_step(k);
          end else begin
            m_cnt[k]++;
          end
        end
        if (mode != 2'd3) m_dir[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d0_pattern", int'(bus0.pattern), m_pat[0]);
      chk("d0_index",   int'(bus0.index),   low_bit(m_pat[0]));
      chk("d0_wrap",    int'(bus0.wrap),    m_wrap[0]);
      chk("d0_seg",     int'(bus0.seg),     exp_seg[low_bit(m_pat[0])]);
      chk("d1_pattern", int'(bus1.pattern), m_pat[1]);
      chk("d1_index",   int'(bus1.index),   low_bit(m_pat[1]));
      chk("d1_wrap",    int'(bus1.wrap),    m_wrap[1]);
      chk("d1_seg",     int'(bus1.seg),     exp_seg[low_bit(m_pat[1])]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int t1_pat [4] = '{2, 4, 8, 1};
  int t1_seg [4] = '{'h06, 'h5B, 'h4F, 'h3F};
  int t2_pat [8] = '{2, 4, 8, 4, 2, 1, 2, 4};
  int t3_pat [8] = '{1, 3, 7, 15, 14, 12, 8, 0};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; ld = 1'b0; ld_val = '0; chk_en = 1'b0;
    tick();
    chk_en = 1'b1;
    do_reset();
    chk("rst_pattern", int'(bus0.pattern), 1);
    chk("rst_index",   int'(bus0.index),   0);
    chk("rst_wrap",    int'(bus0.wrap),    0);
    chk("rst_seg",     int'(bus0.seg),     'h3F);

    // Ring left walk with wrap on 8->1.
    mode = 2'd0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_pattern", int'(bus0.pattern), t1_pat[i]);
      chk("t1_wrap",    int'(bus0.wrap),    (i == 3) ? 1 : 0);
      chk("t1_seg",     int'(bus0.seg),     t1_seg[i]);
    end

    // Ping-pong, then a switch to ring right while descending.
    do_reset();
    mode = 2'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_pattern", int'(bus0.pattern), t2_pat[i]);
      chk("t2_wrap",    int'(bus0.wrap),    (i == 5) ? 1 : 0);
    end
    do_reset();
    repeat (4) tick();
    chk("t2_at4", int'(bus0.pattern), 4);
    mode = 2'd1;
    tick(); chk("t2_rr0", int'(bus0.pattern), 2);
    tick(); chk("t2_rr1", int'(bus0.pattern), 1);
    tick(); chk("t2_rr2", int'(bus0.pattern), 8);
    chk("t2_rr2_wrap", int'(bus0.wrap), 1);

    // Johnson from zero.
    ld = 1'b1; ld_val = '0; mode = 2'd2;
    tick();
    ld = 1'b0;
    chk("t3_load0", int'(bus0.pattern), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_pattern", int'(bus0.pattern), t3_pat[i]);
      chk("t3_wrap",    int'(bus0.wrap),    (i == 7) ? 1 : 0);
    end

    // Non-one-hot load recovers on the next step; reset beats load.
    mode = 2'd0; ld = 1'b1; ld_val = 4'b0110;
    tick();
    ld = 1'b0;
    chk("t5_load_pat", int'(bus0.pattern), 6);
    chk("t5_load_idx", int'(bus0.index),   1);
    tick();
    chk("t5_rec_pat",  int'(bus0.pattern), 1);
    chk("t5_rec_idx",  int'(bus0.index),   0);
    chk("t5_rec_wrap", int'(bus0.wrap),    0);
    ld = 1'b1; ld_val = 4'b1000; rst = 1'b1;
    tick();
    ld = 1'b0; rst = 1'b0;
    chk("t5_rst_over_load", int'(bus0.pattern), 1);

    // Prescale 3 with a 5-cycle enable gap mid-count.
    do_reset();
    mode = 2'd0; en = 1'b1;
    tick();
    en = 1'b0;
    repeat (5) tick();
    chk("t4_hold", int'(bus1.pattern), 1);
    en = 1'b1;
    tick(); chk("t4_pre", int'(bus1.pattern), 1);
    tick(); chk("t4_step", int'(bus1.pattern), 2);

    // Reset just before the wrap step.
    do_reset();
    repeat (3) tick();
    chk("t6_at8", int'(bus0.pattern), 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_pat",  int'(bus0.pattern), 1);
    chk("t6_wrap", int'(bus0.wrap),    0);
    chk("t6_seg",  int'(bus0.seg),     'h3F);
    tick(); chk("t6_r0", int'(bus0.pattern), 2);
    tick(); chk("t6_r1", int'(bus0.pattern), 4);

    // Randomised traffic checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      en     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      ld     = ($urandom_range(0, 29) == 0);
      ld_val = W'($urandom_range(0, 15));
      rst    = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; ld = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
